// File: rtl/ora_misr_checker.sv
// Output-response analyser: steps a vector index across a combinational DUT, compacts its
// 1-bit response into a MISR and compares against GOLDEN. Define ORA_TRUTH_EN to capture the truth table.
module ora_misr_checker #(
    parameter int                N_VEC  = 16,
    parameter int                SIG_W  = 8,
    parameter logic [SIG_W-1:0]  POLY   = 8'h1D,
    parameter logic [SIG_W-1:0]  SEED   = 8'h01,
    parameter logic [SIG_W-1:0]  GOLDEN = 8'h4C,
    localparam int               IDX_W  = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic             din,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [N_VEC-1:0] truth
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

    // One MISR shift: Galois feedback on the outgoing MSB, response bit folded into the LSB.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur, input logic bit_in);
        logic [SIG_W-1:0] fb;
        if (cur[SIG_W-1]) begin
            fb = POLY;
        end else begin
            fb = {SIG_W{1'b0}};
        end
        return {cur[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, bit_in};
    endfunction

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [SIG_W-1:0] sig_r, sig_s;
    logic             pass_r, pass_s;
    logic             busy_r, done_r;
`ifdef ORA_TRUTH_EN
    logic [N_VEC-1:0] truth_r, truth_s;
`endif

    // Next-state and datapath decode; start always wins over vld in IDLE/DONE.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        sig_s   = sig_r;
        pass_s  = pass_r;
`ifdef ORA_TRUTH_EN
        truth_s = truth_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                    idx_s   = {IDX_W{1'b0}};
                    sig_s   = SEED;
                    pass_s  = 1'b0;
`ifdef ORA_TRUTH_EN
                    truth_s = {N_VEC{1'b0}};
`endif
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (vld) begin
                    sig_s = misr_step(sig_r, din);
`ifdef ORA_TRUTH_EN
                    truth_s[idx_r] = din;
`endif
                    if (idx_r == LAST_IDX) begin
                        state_s = CHECK;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            CHECK: begin
                pass_s  = (sig_r == GOLDEN);
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            sig_r   <= {SIG_W{1'b0}};
            pass_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            sig_r   <= sig_s;
            pass_r  <= pass_s;
            busy_r  <= (state_s == RUN) || (state_s == CHECK);
            done_r  <= (state_s == DONE);
        end
    end

`ifdef ORA_TRUTH_EN
    // Captured per-vector response, LSB = vector 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            truth_r <= {N_VEC{1'b0}};
        end else begin
            truth_r <= truth_s;
        end
    end
    assign truth = truth_r;
`else
    assign truth = {N_VEC{1'b0}};
`endif

    assign vec_idx = idx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;
    assign sig     = sig_r;

endmodule

// File: tb/tb_ora_misr_checker.sv
// Scoreboard bench for ora_misr_checker: expected MISR values are queued as samples are driven
// and popped when the DUT registers them.
module tb_ora_misr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vld = 1'b0;
    logic        din = 1'b0;
    logic [3:0]  vec_idx;
    logic        busy, done, pass;
    logic [7:0]  sig;
    logic [15:0] truth;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb_q[$];
    logic [7:0] trace [16];

    ora_misr_checker dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .din(din),
        .vec_idx(vec_idx), .busy(busy), .done(done), .pass(pass),
        .sig(sig), .truth(truth)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_step(input logic [7:0] s, input logic d);
        logic [7:0] r;
        r = {s[6:0], 1'b0} ^ {7'd0, d};
        if (s[7]) r = r ^ 8'h1D;
        return r;
    endfunction

    // Full run: start (optionally with vld), N samples, optional start pulse mid-run, CHECK, DONE.
    task automatic run_vectors(input logic [15:0] pat, input bit gaps, input int restart_at,
                               input bit vld_on_start, input logic exp_pass);
        logic [7:0]  m;
        logic [7:0]  got;
        logic [3:0]  idx;
        logic [15:0] exp_truth;
        int cycles;
        int n;
        start = 1'b1; vld = vld_on_start; din = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (sig !== 8'h01 || vec_idx !== 4'd0 || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL run_start: sig=%h idx=%0d busy=%b done=%b pass=%b, want 01 0 1 0 0",
                     sig, vec_idx, busy, done, pass);
        end
        m = 8'h01; idx = 4'd0; n = 0; cycles = 0;
        while (n < 16 && cycles < 200) begin
            vld   = gaps ? (cycles % 2 == 1) : 1'b1;
            din   = pat[idx];
            start = (n == restart_at && vld) ? 1'b1 : 1'b0;
            if (vld) begin
                m = model_step(m, din);
                sb_q.push_back(m);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (vld) begin
                got = sb_q.pop_front();
                trace[n] = sig;
                checks++;
                if (sig !== got) begin
                    errors++;
                    $display("FAIL sample_sig[%0d]: got %h want %h", n, sig, got);
                end
                n++;
                if (idx != 4'd15) idx = idx + 4'd1;
                checks++;
                if (vec_idx !== idx) begin
                    errors++;
                    $display("FAIL sample_idx[%0d]: got %0d want %0d", n, vec_idx, idx);
                end
            end else begin
                checks++;
                if (sig !== m || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gap_hold: sig=%h busy=%b want %h 1", sig, busy, m);
                end
            end
            cycles++;
        end
        vld = 1'b0; din = 1'b0;
        checks++;
        if (cycles != (gaps ? 32 : 16)) begin
            errors++;
            $display("FAIL run_cycles: got %0d want %0d", cycles, gaps ? 32 : 16);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL check_state: busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge clk); #1;
`ifdef ORA_TRUTH_EN
        exp_truth = pat;
`else
        exp_truth = 16'h0000;
`endif
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== exp_pass || sig !== m
            || vec_idx !== 4'd15 || truth !== exp_truth) begin
            errors++;
            $display("FAIL run_done: done=%b busy=%b pass=%b sig=%h idx=%0d truth=%h want 1 0 %b %h 15 %h",
                     done, busy, pass, sig, vec_idx, truth, exp_pass, m, exp_truth);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vld = 1'b0; din = 1'b0;
        #12;
        checks++;
        if ({vec_idx, busy, done, pass, sig, truth} !== 31'd0) begin
            errors++;
            $display("FAIL reset_vals: idx=%0d busy=%b done=%b pass=%b sig=%h truth=%h want all 0",
                     vec_idx, busy, done, pass, sig, truth);
        end
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({vec_idx, busy, done, pass, sig, truth} !== 31'd0) begin
            errors++;
            $display("FAIL idle_hold: idx=%0d busy=%b done=%b sig=%h want all 0", vec_idx, busy, done, sig);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_seq [16];
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D,
                    8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C};
        run_vectors(16'h0000, 1'b0, -1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (trace[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d]: got %h want %h", i, trace[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_last_one();
        run_vectors(16'h8000, 1'b0, -1, 1'b0, 1'b0);
        checks++;
        if (sig !== 8'h4D || pass !== 1'b0) begin
            errors++;
            $display("FAIL last_one: sig=%h pass=%b want 4D 0", sig, pass);
        end
    endtask

    task automatic test_gaps();
        run_vectors(16'h0000, 1'b1, -1, 1'b0, 1'b1);
        checks++;
        if (sig !== 8'h4C || pass !== 1'b1) begin
            errors++;
            $display("FAIL gaps: sig=%h pass=%b want 4C 1", sig, pass);
        end
    endtask

    task automatic test_restart();
        run_vectors(16'hA5C3, 1'b0, 5, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done=%b want 1", done);
        end
        // start from DONE with vld/din=1 in the same cycle: sample ignored, sig reloads SEED
        run_vectors(16'h0000, 1'b0, -1, 1'b1, 1'b1);
        checks++;
        if (sig !== 8'h4C) begin
            errors++;
            $display("FAIL restart_sig: got %h want 4C", sig);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; vld = 1'b1; din = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (vec_idx !== 4'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_idx: idx=%0d busy=%b want 9 1", vec_idx, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sig !== 8'h00 || vec_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || truth !== 16'h0000) begin
            errors++;
            $display("FAIL midrun_reset: sig=%h idx=%0d busy=%b done=%b truth=%h want 00 0 0 0 0000",
                     sig, vec_idx, busy, done, truth);
        end
        vld = 1'b0; din = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_vectors(16'h0000, 1'b0, -1, 1'b0, 1'b1);
        checks++;
        if (sig !== 8'h4C) begin
            errors++;
            $display("FAIL post_reset_sig: got %h want 4C", sig);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_one();
        test_gaps();
        test_restart();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
